// File: rtl/opu_pkg.sv
// Shared definitions for the operation processing unit: opcodes, FSM states,
// and the fixed bit-serial parameters used by MUL and CRC.
package opu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_CRC  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam int         STEPS    = 8;
  localparam int         STEP_W   = $clog2(STEPS);

endpackage

// File: rtl/opu_step_unit.sv
// One bit-serial step of the multi-cycle ops: shift-add multiply or CRC-8
// (poly 0x07, MSB first). Purely combinational; registers live in op_unit.
module opu_step_unit
  import opu_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  op_t               op,
  input  logic [STEP_W-1:0] step,
  input  logic [ACC_W+7:0]  prod,
  input  logic [ACC_W-1:0]  mcand,
  input  logic [7:0]        mplier,
  input  logic [7:0]        crc,
  output logic [ACC_W+7:0]  prod_next,
  output logic [7:0]        mplier_next,
  output logic [7:0]        crc_next
);

  logic [ACC_W+7:0] partial;

  assign partial = (ACC_W + 8)'(mcand) << step;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    prod_next   = prod;
    mplier_next = mplier;
    crc_next    = crc;
    unique case (op)
      OP_MUL: begin
        if (mplier[0]) prod_next = prod + partial;
        mplier_next = mplier >> 1;
      end
      OP_CRC: begin
        crc_next = crc[7] ? ({crc[6:0], 1'b0} ^ CRC_POLY) : {crc[6:0], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/op_unit.sv
// Operation processing unit: accepts LOAD/ADD/MUL/CRC requests against an
// accumulator, pulses op_done once per operation, exposes acc and sticky ovf.
module op_unit
  import opu_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_start,
  input  logic [1:0]       op_code,
  input  logic [7:0]       data,
  output logic             op_done,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  state_t            state, state_next;
  op_t               op_q;
  logic [STEP_W-1:0] step_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W+7:0]  prod, prod_next;
  logic [ACC_W-1:0]  mcand;
  logic [7:0]        mplier, mplier_next;
  logic [7:0]        crc, crc_next;
  logic [ACC_W:0]    add_sum;
  logic              accept;
  logic              last_step;

  assign accept    = (state == IDLE) && op_start;
  assign last_step = (state == EXEC) && (step_cnt == STEP_W'(STEPS - 1));
  assign add_sum   = {1'b0, acc} + (ACC_W + 1)'(data);

  opu_step_unit #(.ACC_W(ACC_W)) u_step (
    .op          (op_q),
    .step        (step_cnt),
    .prod        (prod),
    .mcand       (mcand),
    .mplier      (mplier),
    .crc         (crc),
    .prod_next   (prod_next),
    .mplier_next (mplier_next),
    .crc_next    (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // DONE always falls back to IDLE, so a request still held in DONE is not re-accepted.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (op_start) begin
          if (op_code == OP_MUL || op_code == OP_CRC) state_next = EXEC;
          else                                        state_next = DONE;
        end
      end
      EXEC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so an aborted MUL/CRC leaves
    // no stale operand behind and the unit restarts from a known state.
    if (!rst_n) begin
      op_q     <= OP_LOAD;
      step_cnt <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      crc      <= '0;
    end else if (accept) begin
      op_q     <= op_t'(op_code);
      step_cnt <= '0;
      unique case (op_t'(op_code))
        OP_LOAD: begin
          acc <= ACC_W'(data);
          ovf <= 1'b0;
        end
        OP_ADD: begin
          acc <= add_sum[ACC_W-1:0];
          ovf <= ovf | add_sum[ACC_W];
        end
        OP_MUL: begin
          prod   <= '0;
          mcand  <= acc;
          mplier <= data;
        end
        OP_CRC:  crc <= acc[7:0] ^ data;
        default: ;
      endcase
    end else if (state == EXEC) begin
      step_cnt <= step_cnt + 1'b1;
      prod     <= prod_next;
      mplier   <= mplier_next;
      crc      <= crc_next;
      if (last_step) begin
        if (op_q == OP_MUL) begin
          acc <= prod_next[ACC_W-1:0];
          ovf <= ovf | (|prod_next[ACC_W+7:ACC_W]);
        end else begin
          acc <= ACC_W'(crc_next);
        end
      end
    end
  end

  assign op_done = (state == DONE);
  assign busy    = (state != IDLE) || op_start;
  assign result  = acc;

endmodule

// File: tb/tb_op_unit.sv
// Directed bench for op_unit: reset, LOAD/ADD overflow, MUL latency and
// overflow, CRC vectors, server handshake and reset during MUL.
module tb_op_unit;
  import opu_pkg::*;

  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_start;
  logic [1:0]       op_code;
  logic [7:0]       data;
  logic             op_done;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  op_unit #(.ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_start (op_start),
    .op_code  (op_code),
    .data     (data),
    .op_done  (op_done),
    .busy     (busy),
    .result   (result),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Server-style request: raise op_start, hold it until op_done is seen,
  // then drop it. lat is the number of cycles from accept edge to op_done.
  task automatic do_op(input logic [1:0] c, input logic [7:0] d, input int lat,
                       input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    op_start = 1'b1;
    op_code  = c;
    data     = d;
    #1 check({tag, " busy_on_req"}, 32'(busy), 32'd1);
    do begin
      @(negedge clk);
      cnt++;
    end while (!op_done && cnt < 20);
    check({tag, " latency"}, 32'(cnt), 32'(lat));
    op_start = 1'b0;
    @(negedge clk);
    check({tag, " single_pulse"}, 32'(op_done), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    op_start = 1'b0;
    op_code  = 2'b00;
    data     = 8'h00;

    // Reset state
    #12;
    check("rst result", 32'(result), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst op_done", 32'(op_done), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD / ADD with overflow: 0xFF + 256*0xFF = 0xFFFF, then +1 wraps
    do_op(OP_LOAD, 8'hFF, 1, "load_ff");
    check("load_ff result", 32'(result), 32'h00FF);
    for (int i = 0; i < 256; i++) do_op(OP_ADD, 8'hFF, 1, "add_ff");
    check("add to ffff result", 32'(result), 32'hFFFF);
    check("add to ffff ovf", 32'(ovf), 32'd0);
    do_op(OP_ADD, 8'h01, 1, "add_wrap");
    check("add_wrap result", 32'(result), 32'h0000);
    check("add_wrap ovf", 32'(ovf), 32'd1);
    do_op(OP_ADD, 8'h02, 1, "add_sticky");
    check("add_sticky result", 32'(result), 32'h0002);
    check("add_sticky ovf", 32'(ovf), 32'd1);
    do_op(OP_LOAD, 8'h00, 1, "load_clr");
    check("load_clr ovf", 32'(ovf), 32'd0);

    // MUL latency and result
    do_op(OP_LOAD, 8'h12, 1, "load_12");
    do_op(OP_MUL, 8'h0A, 9, "mul_0a");
    check("mul_0a result", 32'(result), 32'h00B4);
    check("mul_0a ovf", 32'(ovf), 32'd0);

    // MUL overflow: 0x40*0x40 = 0x1000, then *0x20 = 0x20000
    do_op(OP_LOAD, 8'h40, 1, "load_40");
    do_op(OP_MUL, 8'h40, 9, "mul_40");
    check("mul_40 result", 32'(result), 32'h1000);
    check("mul_40 ovf", 32'(ovf), 32'd0);
    do_op(OP_MUL, 8'h20, 9, "mul_20");
    check("mul_20 result", 32'(result), 32'h0000);
    check("mul_20 ovf", 32'(ovf), 32'd1);

    // CRC vectors; ovf stays set from the MUL overflow
    do_op(OP_CRC, 8'h01, 9, "crc_01");
    check("crc_01 result", 32'(result), 32'h0007);
    check("crc_01 ovf", 32'(ovf), 32'd1);
    do_op(OP_LOAD, 8'h00, 1, "load_00");
    do_op(OP_CRC, 8'h80, 9, "crc_80");
    check("crc_80 result", 32'(result), 32'h0089);
    check("crc_80 ovf", 32'(ovf), 32'd0);

    // Handshake: op_start held throughout, operands toggled during EXEC
    do_op(OP_LOAD, 8'h03, 1, "hs_load");
    @(negedge clk);
    op_start = 1'b1;
    op_code  = OP_MUL;
    data     = 8'h05;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("hs exec op_done", 32'(op_done), 32'd0);
      check("hs exec result held", 32'(result), 32'h0003);
      check("hs exec busy", 32'(busy), 32'd1);
      op_code = i[0] ? OP_ADD : OP_LOAD;
      data    = 8'(i * 37);
    end
    @(negedge clk);
    check("hs mul done", 32'(op_done), 32'd1);
    check("hs mul result", 32'(result), 32'h000F);
    op_code = OP_LOAD;
    data    = 8'h77;
    @(negedge clk);
    check("hs no reaccept in done", 32'(op_done), 32'd0);
    check("hs idle busy", 32'(busy), 32'd1);
    check("hs idle result", 32'(result), 32'h000F);
    @(negedge clk);
    check("hs reaccept done", 32'(op_done), 32'd1);
    check("hs reaccept result", 32'(result), 32'h0077);
    op_start = 1'b0;
    @(negedge clk);
    check("hs final op_done", 32'(op_done), 32'd0);
    check("hs final busy", 32'(busy), 32'd0);

    // Reset in the middle of a MUL
    do_op(OP_LOAD, 8'h12, 1, "rmul_load");
    @(negedge clk);
    op_start = 1'b1;
    op_code  = OP_MUL;
    data     = 8'h0A;
    repeat (4) @(negedge clk);
    check("rmul mid result", 32'(result), 32'h0012);
    check("rmul mid op_done", 32'(op_done), 32'd0);
    @(posedge clk);
    #1;
    op_start = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rmul rst result", 32'(result), 32'd0);
    check("rmul rst ovf", 32'(ovf), 32'd0);
    check("rmul rst busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rmul rst no op_done", 32'(op_done), 32'd0);
      if (i == 1) rst_n = 1'b1;
    end
    do_op(OP_LOAD, 8'h05, 1, "rmul_reload");
    check("rmul reload result", 32'(result), 32'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
